// File: rtl/thrd_cmd_seq.sv
// Thread command sequencer.
// Commands (KILL / SLEEP / WAKE) are queued in a small FIFO, pre-checked
// against the thread controller's valid/run masks, and issued one at a time
// as single-cycle pulses. Per-thread sleep timers produce self-generated
// WAKE commands that take priority over queued commands.
//
// Handshake: a command transfers on any rising edge where req_valid and
// req_ready are both high; req_ready depends only on FIFO occupancy, so a
// requester may hold req_valid and its payload stable until it sees ready.
module thrd_cmd_seq #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_op,
  input  logic [2:0] req_act,
  input  logic [2:0] req_obj,
  input  logic [7:0] req_tmo,
  input  logic       stall,
  input  logic [7:0] valid_thrd,
  input  logic [7:0] run_thrd,
  input  logic       invalid_op,
  output logic       kill,
  output logic       slp,
  output logic       wake,
  output logic [2:0] act_thrd,
  output logic [2:0] obj_thrd,
  output logic       busy,
  output logic       cmd_err,
  output logic [2:0] err_thrd
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  localparam logic [1:0] OP_KILL  = 2'b00;
  localparam logic [1:0] OP_SLEEP = 2'b01;
  localparam logic [1:0] OP_WAKE  = 2'b10;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_CHECK} state_t;

  state_t        state_q;
  logic [15:0]   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          fifo_empty, push, pop;
  logic [15:0]   head;
  logic [1:0]    h_op;
  logic [2:0]    h_act, h_obj;
  logic [7:0]    h_tmo;
  logic          head_ok;

  logic [1:0]    cmd_op;
  logic [2:0]    cmd_act, cmd_obj;
  logic [7:0]    cmd_tmo;
  logic [2:0]    act_hold, obj_hold;
  logic          issue;

  logic [7:0]    timer [8];
  logic [7:0]    wake_pend;
  logic          pend_any, pend_ok;
  logic [2:0]    pend_sel;
  logic [7:0]    sel_clr, expire, issue_clr;

  assign fifo_empty = (count == '0);
  assign req_ready  = (count != FULL_CNT);
  assign push       = req_valid && req_ready;
  assign pend_any   = |wake_pend;
  // Timer wakes pre-empt the FIFO, so the head is only consumed with no wake pending.
  assign pop        = (state_q == ST_IDLE) && !pend_any && !fifo_empty;

  assign head  = fifo_mem[rd_ptr];
  assign h_op  = head[15:14];
  assign h_act = head[13:11];
  assign h_obj = head[10:8];
  assign h_tmo = head[7:0];

  // Pulses decode straight from the ISSUE state so a command reaches the
  // thread controller one cycle after it leaves the FIFO.
  assign issue    = (state_q == ST_ISSUE) && !stall;
  assign kill     = issue && (cmd_op == OP_KILL);
  assign slp      = issue && (cmd_op == OP_SLEEP);
  assign wake     = issue && (cmd_op == OP_WAKE);
  assign act_thrd = issue ? cmd_act : act_hold;
  assign obj_thrd = issue ? cmd_obj : obj_hold;
  assign busy     = !fifo_empty || (state_q != ST_IDLE) || pend_any;

  // Head-of-queue legality check against the current thread masks.
  always_comb begin
    head_ok = 1'b0;
    case (h_op)
      OP_KILL, OP_SLEEP: head_ok = valid_thrd[h_obj];
      OP_WAKE:           head_ok = valid_thrd[h_obj] && !run_thrd[h_obj];
      default:           head_ok = 1'b0;
    endcase
  end

  // Lowest-numbered pending wake and whether it may actually be issued.
  always_comb begin
    pend_sel = '0;
    for (int t = 7; t >= 0; t--) begin
      if (wake_pend[t]) pend_sel = 3'(t);
    end
    pend_ok = valid_thrd[pend_sel] && !run_thrd[pend_sel];
    sel_clr = ((state_q == ST_IDLE) && pend_any) ? (8'b1 << pend_sel) : 8'b0;
  end

  // Per-thread expiry and issue-time cancel masks; an issue to a thread
  // overrides an expiry landing in the same cycle.
  always_comb begin
    expire    = '0;
    issue_clr = '0;
    for (int t = 0; t < 8; t++) begin
      expire[t]    = (timer[t] == 8'd1) && !(issue && (cmd_obj == 3'(t)));
      issue_clr[t] = issue && (cmd_obj == 3'(t)) && (cmd_op != OP_SLEEP);
    end
  end

  // FIFO storage; contents need no reset because the pointers are flushed.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {req_op, req_act, req_obj, req_tmo};
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sleep timers: load on SLEEP issue, cancel on WAKE/KILL issue, else count down.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int t = 0; t < 8; t++) timer[t] <= '0;
      wake_pend <= '0;
    end else begin
      for (int t = 0; t < 8; t++) begin
        if (issue && (cmd_obj == 3'(t)) && (cmd_op == OP_SLEEP)) timer[t] <= cmd_tmo;
        else if (issue_clr[t])                                   timer[t] <= '0;
        else if (timer[t] != '0)                                 timer[t] <= timer[t] - 8'd1;
      end
      wake_pend <= ((wake_pend & ~sel_clr) | expire) & ~issue_clr;
    end
  end

  // Command FSM: select (IDLE) -> pulse (ISSUE) -> controller verdict (CHECK).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cmd_op   <= OP_KILL;
      cmd_act  <= '0;
      cmd_obj  <= '0;
      cmd_tmo  <= '0;
      act_hold <= '0;
      obj_hold <= '0;
      cmd_err  <= 1'b0;
      err_thrd <= '0;
    end else begin
      cmd_err <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (pend_any) begin
            // A stale wake (thread gone or already running) is dropped silently.
            if (pend_ok) begin
              cmd_op  <= OP_WAKE;
              cmd_act <= pend_sel;
              cmd_obj <= pend_sel;
              cmd_tmo <= '0;
              state_q <= ST_ISSUE;
            end
          end else if (!fifo_empty) begin
            if (head_ok) begin
              cmd_op  <= h_op;
              cmd_act <= h_act;
              cmd_obj <= h_obj;
              cmd_tmo <= h_tmo;
              state_q <= ST_ISSUE;
            end else begin
              cmd_err  <= 1'b1;
              err_thrd <= h_obj;
            end
          end
        end
        ST_ISSUE: begin
          if (!stall) begin
            act_hold <= cmd_act;
            obj_hold <= cmd_obj;
            state_q  <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (invalid_op) begin
            cmd_err  <= 1'b1;
            err_thrd <= cmd_obj;
          end
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/thrd_cmd_seq.md
THRD_CMD_SEQ -- requirements
Module: thrd_cmd_seq

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning the number of command-queue entries (power of 2, at least 2).
REQ-002 SHALL have these ports, one per line as name, direction, width, meaning:
  clk  in  1  single clock; all state changes on its rising edge.
  rst_n  in  1  reset; asynchronous, active-low.
  req_valid  in  1  a command is offered.
  req_ready  out  1  the block accepts the command (= !fifo_full).
  req_op  in  2  00 KILL, 01 SLEEP, 10 WAKE, 11 reserved.
  req_act  in  3  thread issuing the command.
  req_obj  in  3  target thread.
  req_tmo  in  8  SLEEP timeout in cycles; 0 = sleep until an explicit WAKE.
  stall  in  1  pipeline stall; no command is issued while it is high.
  valid_thrd  in  8  valid-thread mask from the thread controller.
  run_thrd  in  8  running (non-sleeping) mask from the thread controller.
  invalid_op  in  1  thread controller's reject flag, sampled one cycle after issue.
  kill / slp / wake  out  1 each  one-hot, single-cycle command pulses to the thread controller.
  act_thrd, obj_thrd  out  3 each  thread IDs qualifying the pulse.
  busy  out  1  FIFO non-empty, or FSM not in IDLE, or any wake_pend bit set.
  cmd_err  out  1  one-cycle pulse on a dropped or rejected command.
  err_thrd  out  3  obj of the last erroring command; holds until the next error.

Function
REQ-003 SHALL push {op,act,obj,tmo} into the FIFO when req_valid && req_ready; a push and a pop may occur in the same cycle.
REQ-004 SHALL implement FSM states IDLE, ISSUE, CHECK.
REQ-005 IDLE, when any wake_pend bit is set: SHALL select the lowest-numbered pending thread t, load cmd = WAKE with act = obj = t, and go to ISSUE; timer wakes take priority over the FIFO.
REQ-006 IDLE, otherwise, with FIFO non-empty: SHALL pre-check the head entry, then pop it.
  - Pass: load cmd, go to ISSUE.
  - Fail: go to neither ISSUE nor CHECK; pulse cmd_err, set err_thrd = obj, stay in IDLE.
REQ-007 Pre-check fails on any of:
  - op = 11;
  - KILL or SLEEP with valid_thrd[obj] = 0;
  - WAKE with valid_thrd[obj] = 0 or run_thrd[obj] = 1.
REQ-008 ISSUE, stall = 1: SHALL hold all pulses low and remain in ISSUE.
REQ-009 ISSUE, stall = 0: SHALL drive exactly one of kill/slp/wake high for that one cycle, with act_thrd/obj_thrd = cmd, then go to CHECK.
REQ-010 CHECK: SHALL sample invalid_op; if it is 1, pulse cmd_err and set err_thrd = obj; always return to IDLE.
REQ-011 Minimum issue latency SHALL be 1 cycle from IDLE to the pulse; sustained throughput SHALL be one command per 3 cycles.
REQ-012 act_thrd/obj_thrd SHALL hold their last value when no pulse is active; kill/slp/wake SHALL never be high in the same cycle.
REQ-013 SHALL keep eight 8-bit sleep timers. An issued SLEEP with tmo != 0 loads timer[obj] = tmo; an issued SLEEP with tmo = 0 clears timer[obj].
REQ-014 Each non-zero timer SHALL decrement by 1 per cycle, regardless of stall. The 1 -> 0 transition SHALL set wake_pend[t].
REQ-015 An issued WAKE or KILL of thread t (FIFO- or timer-sourced) SHALL clear timer[t] and wake_pend[t] in the issue cycle.
REQ-016 A wake_pend[t] selected in IDLE while valid_thrd[t] = 0 or run_thrd[t] = 1 SHALL be cleared silently: no cmd_err, no ISSUE.
REQ-017 A timer expiring on the same cycle its thread is issued a WAKE/KILL SHALL NOT leave wake_pend set (the clear wins).
REQ-018 With FIFO full, req_ready = 0 and offered commands SHALL be stalled, not dropped. FIFO pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-019 rst_n low SHALL asynchronously:
  - flush the FIFO, zero all timers and wake_pend, set the FSM to IDLE;
  - drive kill = slp = wake = cmd_err = busy = 0, act_thrd = obj_thrd = err_thrd = 0, req_ready = 1.
REQ-020 Reset asserted in ISSUE or CHECK SHALL abort the command with no pulse emitted after reset.

Verification
REQ-021 Basic kill: valid_thrd = 0x03, run_thrd = 0x03, push KILL act = 0 obj = 1, stall = 0 -> kill high exactly one cycle, 1 cycle after the pop, obj_thrd = 1, no cmd_err.
REQ-022 Timed sleep: push SLEEP obj = 2 tmo = 5; after the slp pulse the model clears run_thrd[2] -> wake pulse with act = obj = 2 occurs 5 cycles after slp plus FSM latency; busy = 0 afterwards.
REQ-023 Stall and full: stall held 10 cycles, 5 pushes -> first command is held in ISSUE, FIFO holds 4, req_ready = 0; after stall drops, all 5 commands issue in order, none lost.
REQ-024 Errors:
  - op = 11 -> cmd_err pulse, err_thrd = obj, no kill/slp/wake pulse;
  - WAKE of a running thread -> dropped with cmd_err;
  - invalid_op = 1 in CHECK -> cmd_err pulse.
REQ-025 Priority/cancel: timers for threads 3 and 5 expire on the same cycle while the FIFO holds a command -> wake 3, then wake 5, then the FIFO command. A KILL of 5 issued before its expiry -> no wake 5.
REQ-026 Reset mid-ISSUE under stall -> all outputs return to reset values immediately; no pulse after release; req_ready = 1.
